lcd_capture: RTL and testbench
==============================

Name: lcd_capture

Overview:
- Receiving end of the PPU LCD pin interface: the panel-side decoder.
- Oversamples the active-low LCD pins on clk6 and reconstructs pixel x/y positions.
- Writes each 2-bit pixel into a 160x144 framebuffer write port and reports frame and sync-integrity status.
- Used in the SoC simulation top and the FPGA video output path, downstream of the PPU LCD outputs.

Parameters:
H_PIXELS, 160, pixels per line
V_LINES, 144, visible lines per frame
SYNC_STAGES, 2, input synchroniser depth (2 or 3)
TIMEOUT, 65535, clk6 cycles without a pixel-clock edge before lcd_on drops

Ports:
clk6  input  1  sampling clock; the only clock
reset  input  1  asynchronous, active-high reset
n_lcd_ld1  input  1  pixel data bit 1, active low
n_lcd_ld0  input  1  pixel data bit 0, active low
n_lcd_cp  input  1  pixel clock, active low
n_lcd_st  input  1  line start strobe, active low
n_lcd_cpl  input  1  line latch strobe, active low
n_lcd_s  input  1  vertical sync, active low
n_lcd_fr  input  1  frame polarity (LCD AC inversion)
n_lcd_cpg  input  1  pixel clock gate; monitored only
fb_addr  output  15  framebuffer write address = y*H_PIXELS + x
fb_data  output  2  pixel colour {~ld1, ~ld0}
fb_we  output  1  one-cycle write strobe
x  output  8  current pixel column
y  output  8  current line
frame_done  output  1  one-cycle pulse: a complete, well-formed frame was captured
frame_err  output  1  sticky: a frame had the wrong line count or FR did not toggle
line_err  output  1  sticky: a line had more or fewer than H_PIXELS pixels
lcd_on  output  1  pixel clock activity detected

Behaviour:
- Reset: all outputs 0; counters and line_base 0; previous-FR register 0; first_frame flag 1.
- Synchronisation: every LCD input passes through SYNC_STAGES flops. Edge detection compares the last sync stage with one extra history flop.
- Latency: pin change to fb_we is SYNC_STAGES+1 clk6 cycles.
- Pixel capture, on a rising edge of the synced n_lcd_cp (0->1):
  - if x < H_PIXELS and y < V_LINES: fb_we=1 for one cycle, fb_data = inverted ld1/ld0 sampled in the same cycle, fb_addr = line_base + x; then x increments;
  - if x >= H_PIXELS: no write, line_err set, x saturates at 255.
  - Pixels with y >= V_LINES are discarded silently.
- Line start, falling edge of n_lcd_st: x <= 0. It does not change y.
- Line end, falling edge of n_lcd_cpl:
  - if x != H_PIXELS and x != 0, line_err is set;
  - then x <= 0, y <= y+1 saturating at 255, line_base <= line_base + H_PIXELS (no increment once y >= V_LINES).
  - An idle line with x == 0 is not an error (LCD-off blanking).
- Frame sync, falling edge of n_lcd_s. It is evaluated after the same-cycle line-end update. Then:
  - good = (y == V_LINES) and (first_frame or n_lcd_fr != previous FR);
  - frame_done = good (one-cycle pulse); frame_err is set if not good and not first_frame;
  - y, x, line_base <= 0; previous FR <= synced n_lcd_fr; first_frame <= 0.
- Simultaneous events in one cycle: cp edge first (write uses pre-update x/line_base), then st, then cpl, then s.
- Activity timer:
  - cleared on each cp edge, increments otherwise, saturates at TIMEOUT;
  - lcd_on = 1 after the first cp edge, 0 when the timer reaches TIMEOUT;
  - when lcd_on falls, first_frame <= 1. Sticky errors are kept.
- Sticky errors clear only on reset.
- Reset mid-frame: everything returns to reset values immediately. The next s edge is treated as first_frame, so no error is reported.
- n_lcd_cpg is synchronised but does not gate capture.

Test Plan:
- Full frame: s edge, then 144 lines of 160 cp pulses with pixel value = x[1:0], each ended by cpl, then s edge -> 23040 fb_we strobes; last write addr 23039 data 3; frame_done=1 for one cycle; line_err=0, frame_err=0.
- Long line: 161 cp pulses on line 5 -> 160 writes on that line, line_err=1 from the 161st edge; addr 959 is the last write of line 5.
- Short frame: 143 lines then s edge, on the second frame -> frame_done stays 0, frame_err=1; y=0.
- FR stuck: two consecutive good frames with n_lcd_fr held at 1 -> first frame_done=1, second frame_done=0 and frame_err=1.
- Simultaneous cpl and cp edge on pixel 159 of line 0 -> write addr 159, then x=0, y=1, line_base=160, no line_err.
- Pixel clock stops for TIMEOUT cycles -> lcd_on=0; assert reset mid-line on a following frame -> fb_addr, x, y = 0 asynchronously; the next s edge raises no frame_err.

Source files
------------

// File: rtl/lcd_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_capture
// Purpose  : Panel-side decoder for the PPU LCD pin interface. It oversamples
//            the LCD pins on clk6 and rebuilds the pixel x/y position. Each
//            2-bit pixel is written into a H_PIXELS x V_LINES framebuffer
//            write port. It also reports frame completion and sync integrity.
// Ports    : clk6, reset          - sampling clock, async active-high reset
//            n_lcd_*              - raw LCD pins (data, cp, st, cpl, s, fr, cpg)
//            fb_addr/fb_data/fb_we- framebuffer write port
//            x, y                 - current pixel column / line
//            frame_done           - one-cycle pulse per well-formed frame
//            frame_err, line_err  - sticky integrity flags
//            lcd_on               - pixel clock activity detected
// Revision : 1.0 - initial release
// ============================================================================
module lcd_capture #(
  parameter int H_PIXELS    = 160,
  parameter int V_LINES     = 144,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic        clk6,
  input  logic        reset,
  input  logic        n_lcd_ld1,
  input  logic        n_lcd_ld0,
  input  logic        n_lcd_cp,
  input  logic        n_lcd_st,
  input  logic        n_lcd_cpl,
  input  logic        n_lcd_s,
  input  logic        n_lcd_fr,
  input  logic        n_lcd_cpg,
  output logic [14:0] fb_addr,
  output logic [1:0]  fb_data,
  output logic        fb_we,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic        frame_done,
  output logic        frame_err,
  output logic        line_err,
  output logic        lcd_on
);

  // Bit positions of the pins inside the synchroniser vector.
  localparam int B_LD1 = 7;
  localparam int B_LD0 = 6;
  localparam int B_CP  = 5;
  localparam int B_ST  = 4;
  localparam int B_CPL = 3;
  localparam int B_S   = 2;
  localparam int B_FR  = 1;
  localparam int B_CPG = 0;

  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [7:0]      H_C       = 8'(H_PIXELS);
  localparam logic [7:0]      V_C       = 8'(V_LINES);
  localparam logic [14:0]     H_W       = 15'(H_PIXELS);

  logic [7:0] pins;
  assign pins = {n_lcd_ld1, n_lcd_ld0, n_lcd_cp, n_lcd_st,
                 n_lcd_cpl, n_lcd_s, n_lcd_fr, n_lcd_cpg};

  // Synchroniser chain. Flops reset to the idle (high) pin level so that
  // releasing reset never looks like a strobe edge.
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_d [SYNC_STAGES];
  logic [3:0] hist_q, hist_d;   // {cp, st, cpl, s} one stage behind
  logic [7:0] syn;

  always_comb begin
    sync_d[0] = pins;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign syn    = sync_q[SYNC_STAGES-1];
  assign hist_d = {syn[B_CP], syn[B_ST], syn[B_CPL], syn[B_S]};

  logic cp_rise, st_fall, cpl_fall, s_fall;
  assign cp_rise  =  syn[B_CP]  & ~hist_q[3];
  assign st_fall  = ~syn[B_ST]  &  hist_q[2];
  assign cpl_fall = ~syn[B_CPL] &  hist_q[1];
  assign s_fall   = ~syn[B_S]   &  hist_q[0];

  // The cpg pin is carried through the synchroniser for observation only.
  logic unused_cpg;
  assign unused_cpg = syn[B_CPG];

  logic [7:0]    x_q, x_d, y_q, y_d;
  logic [14:0]   line_base_q, line_base_d;
  logic [14:0]   fb_addr_q, fb_addr_d;
  logic [1:0]    fb_data_q, fb_data_d;
  logic          fb_we_q, fb_we_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic          line_err_q, line_err_d;
  logic          lcd_on_q, lcd_on_d;
  logic          fr_prev_q, fr_prev_d;
  logic          first_frame_q, first_frame_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          good;

  // Events of one cycle are applied in order: cp, st, cpl, s. Each stage
  // works on the values left by the previous one.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    line_base_d   = line_base_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    frame_done_d  = 1'b0;
    frame_err_d   = frame_err_q;
    line_err_d    = line_err_q;
    fr_prev_d     = fr_prev_q;
    first_frame_d = first_frame_q;
    timer_d       = timer_q;
    lcd_on_d      = lcd_on_q;
    good          = 1'b0;

    // Activity timer. Losing the pixel clock re-arms first_frame so the
    // next frame sync after a restart is not judged against stale state.
    if (cp_rise) begin
      timer_d  = '0;
      lcd_on_d = 1'b1;
    end else begin
      if (timer_q != TIMEOUT_C) timer_d = timer_q + TW'(1);
      if (timer_q == TIMEOUT_C) lcd_on_d = 1'b0;
    end
    if (lcd_on_q && !lcd_on_d) first_frame_d = 1'b1;

    if (cp_rise) begin
      if (x_q < H_C) begin
        if (y_q < V_C) begin
          fb_we_d   = 1'b1;
          fb_addr_d = line_base_q + {7'd0, x_q};
          fb_data_d = {~syn[B_LD1], ~syn[B_LD0]};
        end
        x_d = x_q + 8'd1;
      end else begin
        line_err_d = 1'b1;
        if (x_q != 8'hFF) x_d = x_q + 8'd1;
      end
    end

    if (st_fall) x_d = 8'd0;

    if (cpl_fall) begin
      // x == 0 is a blank line (LCD off), not a malformed one.
      if (x_d != H_C && x_d != 8'd0) line_err_d = 1'b1;
      x_d = 8'd0;
      if (y_d < V_C)    line_base_d = line_base_d + H_W;
      if (y_d != 8'hFF) y_d = y_d + 8'd1;
    end

    if (s_fall) begin
      good         = (y_d == V_C) && (first_frame_d || (syn[B_FR] != fr_prev_q));
      frame_done_d = good;
      if (!good && !first_frame_d) frame_err_d = 1'b1;
      x_d           = 8'd0;
      y_d           = 8'd0;
      line_base_d   = 15'd0;
      fr_prev_d     = syn[B_FR];
      first_frame_d = 1'b0;
    end
  end

  always_ff @(posedge clk6 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      hist_q        <= '1;
      x_q           <= 8'd0;
      y_q           <= 8'd0;
      line_base_q   <= 15'd0;
      fb_addr_q     <= 15'd0;
      fb_data_q     <= 2'd0;
      fb_we_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      line_err_q    <= 1'b0;
      lcd_on_q      <= 1'b0;
      fr_prev_q     <= 1'b0;
      first_frame_q <= 1'b1;
      timer_q       <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      hist_q        <= hist_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_base_q   <= line_base_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      fb_we_q       <= fb_we_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      line_err_q    <= line_err_d;
      lcd_on_q      <= lcd_on_d;
      fr_prev_q     <= fr_prev_d;
      first_frame_q <= first_frame_d;
      timer_q       <= timer_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;
  assign x          = x_q;
  assign y          = y_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign line_err   = line_err_q;
  assign lcd_on     = lcd_on_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_capture
// Purpose  : Self-checking bench for lcd_capture. It drives random pixel data
//            through directed frame sequences and checks the design against an
//            event-level reference model of the pin protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_capture;
  localparam int H  = 10;
  localparam int V  = 6;
  localparam int SS = 2;
  localparam int TO = 100;

  logic clk6 = 1'b0;
  logic reset;
  logic n_lcd_ld1, n_lcd_ld0, n_lcd_cp, n_lcd_st, n_lcd_cpl, n_lcd_s, n_lcd_fr, n_lcd_cpg;
  logic [14:0] fb_addr;
  logic [1:0]  fb_data;
  logic        fb_we;
  logic [7:0]  x, y;
  logic        frame_done, frame_err, line_err, lcd_on;

  lcd_capture #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk6(clk6), .reset(reset),
    .n_lcd_ld1(n_lcd_ld1), .n_lcd_ld0(n_lcd_ld0), .n_lcd_cp(n_lcd_cp),
    .n_lcd_st(n_lcd_st), .n_lcd_cpl(n_lcd_cpl), .n_lcd_s(n_lcd_s),
    .n_lcd_fr(n_lcd_fr), .n_lcd_cpg(n_lcd_cpg),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .x(x), .y(y),
    .frame_done(frame_done), .frame_err(frame_err), .line_err(line_err), .lcd_on(lcd_on)
  );

  always #5 clk6 = ~clk6;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk6) cyc <= cyc + 1;

  // Observed writes and frame_done cycles.
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  int done_cnt = 0;
  int last_we_cyc = 0;
  always @(negedge clk6) begin
    if (fb_we === 1'b1) begin
      got_q.push_back({fb_addr, fb_data});
      last_we_cyc = cyc;
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  // Reference model state: position in pixel/line units.
  int mx, my, mdone;
  bit mlerr, mferr, mfirst, mprev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk6);
  endtask

  task automatic m_cp(input logic [1:0] v);
    if (mx < H) begin
      if (my < V) exp_q.push_back({15'(my * H + mx), v});
      mx++;
    end else begin
      mlerr = 1'b1;
      if (mx < 255) mx++;
    end
  endtask

  task automatic m_cpl();
    if (mx != H && mx != 0) mlerr = 1'b1;
    mx = 0;
    if (my < 255) my++;
  endtask

  task automatic m_vs();
    if (my == V && (mfirst || (n_lcd_fr != mprev))) mdone++;
    else if (!mfirst) mferr = 1'b1;
    mx = 0;
    my = 0;
    mprev = n_lcd_fr;
    mfirst = 1'b0;
  endtask

  task automatic pix(input logic [1:0] v);
    n_lcd_ld1 = ~v[1];
    n_lcd_ld0 = ~v[0];
    n_lcd_cp  = 1'b0;
    idle(3);
    n_lcd_cp  = 1'b1;
    m_cp(v);
    idle(3);
  endtask

  task automatic st_pulse();
    n_lcd_st = 1'b0;
    mx = 0;
    idle(3);
    n_lcd_st = 1'b1;
    idle(3);
  endtask

  task automatic cpl_pulse();
    n_lcd_cpl = 1'b0;
    m_cpl();
    idle(3);
    n_lcd_cpl = 1'b1;
    idle(3);
  endtask

  task automatic vs();
    n_lcd_s = 1'b0;
    m_vs();
    idle(3);
    n_lcd_s = 1'b1;
    idle(3);
  endtask

  task automatic frame(input int nl, input int long_idx);
    for (int l = 0; l < nl; l++) begin
      st_pulse();
      for (int p = 0; p < H; p++) pix(2'($urandom_range(0, 3)));
      if (my == long_idx) begin
        #1 chk("pre_long_line_err", {31'd0, line_err}, {31'd0, mlerr});
        pix(2'($urandom_range(0, 3)));
        #1 chk("long_line_err", {31'd0, line_err}, {31'd0, mlerr});
      end
      cpl_pulse();
    end
  endtask

  task automatic check_state(input string tag);
    #1;
    chk({tag, "_x"}, {24'd0, x}, mx);
    chk({tag, "_y"}, {24'd0, y}, my);
    chk({tag, "_line_err"}, {31'd0, line_err}, {31'd0, mlerr});
    chk({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, mferr});
    chk({tag, "_frame_done_cycles"}, done_cnt, mdone);
  endtask

  task automatic check_writes(input string tag);
    int bad;
    #1;
    bad = -1;
    chk({tag, "_write_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    chk({tag, "_first_bad_write"}, bad, -1);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [1:0] v;
    int t0;
    n_lcd_ld1 = 1'b1; n_lcd_ld0 = 1'b1; n_lcd_cp = 1'b1; n_lcd_st = 1'b1;
    n_lcd_cpl = 1'b1; n_lcd_s = 1'b1; n_lcd_fr = 1'b1; n_lcd_cpg = 1'b1;
    reset = 1'b1;
    mx = 0; my = 0; mdone = 0; mlerr = 0; mferr = 0; mfirst = 1; mprev = 0;

    idle(3);
    #1;
    chk("rst_fb_addr", {17'd0, fb_addr}, 0);
    chk("rst_fb_data", {30'd0, fb_data}, 0);
    chk("rst_fb_we", {31'd0, fb_we}, 0);
    chk("rst_x", {24'd0, x}, 0);
    chk("rst_y", {24'd0, y}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_line_err", {31'd0, line_err}, 0);
    chk("rst_lcd_on", {31'd0, lcd_on}, 0);
    @(negedge clk6);
    reset = 1'b0;
    idle(2);

    // First frame sync after reset: nothing to judge yet.
    vs();
    check_state("first_sync");

    // Frame 1: FR toggled, first pixel timed, last pixel of line 0 shares
    // its cycle with the line latch.
    n_lcd_fr = 1'b0;
    st_pulse();
    v = 2'($urandom_range(0, 3));
    n_lcd_ld1 = ~v[1]; n_lcd_ld0 = ~v[0]; n_lcd_cp = 1'b0;
    idle(3);
    n_lcd_cp = 1'b1;
    t0 = cyc;
    m_cp(v);
    idle(3);
    #1 chk("pin_to_we_latency", last_we_cyc - t0, SS + 1);
    for (int p = 1; p < H - 1; p++) pix(2'($urandom_range(0, 3)));
    v = 2'($urandom_range(0, 3));
    n_lcd_ld1 = ~v[1]; n_lcd_ld0 = ~v[0]; n_lcd_cp = 1'b0;
    idle(3);
    n_lcd_cp = 1'b1;
    n_lcd_cpl = 1'b0;
    m_cp(v);
    m_cpl();
    idle(3);
    n_lcd_cpl = 1'b1;
    idle(3);
    check_state("cp_cpl_same_cycle");
    frame(V - 1, -1);
    vs();
    check_state("frame1");
    chk("frame1_last_addr", {17'd0, got_q[$][16:2]}, V * H - 1);
    chk("frame1_lcd_on", {31'd0, lcd_on}, 1);
    check_writes("frame1");

    // Frame 2: FR toggled again, one overlong line.
    n_lcd_fr = 1'b1;
    frame(V, 2);
    vs();
    check_state("frame2_long_line");
    check_writes("frame2");

    // Frame 3: FR not toggled.
    frame(V, -1);
    vs();
    check_state("fr_stuck");
    check_writes("fr_stuck");

    // Pixel clock stops.
    idle(TO - 20);
    #1 chk("lcd_on_before_timeout", {31'd0, lcd_on}, 1);
    idle(40);
    #1 chk("lcd_on_after_timeout", {31'd0, lcd_on}, 0);
    mfirst = 1'b1;

    // Restart mid-line, then asynchronous reset between clock edges.
    n_lcd_fr = 1'b0;
    st_pulse();
    for (int p = 0; p < 3; p++) pix(2'($urandom_range(0, 3)));
    check_state("restart");
    chk("restart_lcd_on", {31'd0, lcd_on}, 1);
    @(negedge clk6);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_fb_addr", {17'd0, fb_addr}, 0);
    chk("async_rst_x", {24'd0, x}, 0);
    chk("async_rst_y", {24'd0, y}, 0);
    chk("async_rst_lcd_on", {31'd0, lcd_on}, 0);
    mx = 0; my = 0; mlerr = 0; mferr = 0; mfirst = 1; mprev = 0;
    idle(2);
    reset = 1'b0;
    idle(2);
    #1;
    got_q.delete();
    exp_q.delete();
    check_state("post_reset");

    vs();
    check_state("first_sync_after_reset");

    // Short frame.
    n_lcd_fr = ~n_lcd_fr;
    frame(V - 1, -1);
    vs();
    check_state("short_frame");
    check_writes("short_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  // Global watchdog: the bench must always end on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
